program_loader: RTL and testbench

- Host-side producer for the CPU's 16-bit data_in path.
- Receives a byte stream over a valid/ready handshake and assembles 16-bit words, high byte first.
- Writes each word into program memory as one data_word/word_addr/word_we transaction.
- Holds the CPU in reset through cpu_clear during the whole load, then releases it so execution starts from a freshly loaded image.

---
 rtl/program_loader_if.sv | 32 +++
 rtl/program_loader.sv | 161 ++++++++++++++++
 tb/tb_program_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream and program-memory write bundle for program_loader
//
// Signals:
//   byte_in[7:0]            stream data byte (host -> loader)
//   byte_valid              byte_in is valid (host -> loader)
//   byte_ready              loader accepts byte_in this cycle (loader -> host)
//   data_word[15:0]         assembled word (loader -> program memory / CPU data_in)
//   word_addr[ADDR_W-1:0]   write address for data_word (loader -> program memory)
//   word_we                 one-cycle write strobe (loader -> program memory)
// Modports:
//   master  host / memory side
//   slave   loader side
interface program_loader_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [15:0]       data_word;
    logic [ADDR_W-1:0] word_addr;
    logic              word_we;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, data_word, word_addr, word_we
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, data_word, word_addr, word_we
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a byte-streamed image into program memory while holding the CPU in reset
//
// Ports:
//   clk        system clock, rising edge
//   clear      asynchronous active-high reset
//   start      single-cycle pulse that begins a load (ignored unless idle)
//   bus        program_loader_if.slave: byte stream in, word write out
//   cpu_clear  holds the CPU in reset (active-high)
//   busy       load in progress
//   done       one-cycle pulse on a successful load
//   error      sticky error flag, cleared by the next start
// Stream format: N, then N words high byte first.
// Optional macro LOADER_CHECKSUM_EN: one trailing byte equal to the modulo-256
// sum of N and every payload byte; a mismatch ends the load in ERR.
module program_loader #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             cpu_clear,
    output logic             busy,
    output logic             done,
    output logic             error
);
    // One extra bit so that N == 2**ADDR_W does not wrap before the compare.
    localparam int IW = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        GET_CNT,
        GET_HI,
        GET_LO,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        GET_SUM,
`endif
        RELEASE,
        ERR
    } state_t;

    // Where the FSM goes once the last word (or an empty image) is done.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_ST = GET_SUM;
`else
    localparam state_t END_ST = RELEASE;
`endif

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] index;
    logic [IW-1:0] count;
    logic [7:0]    hi;
    logic          fire;
    logic          last_word;
    logic          too_big;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    assign fire      = bus.byte_valid && bus.byte_ready;
    assign last_word = (index + IW'(1)) == count;
    assign too_big   = {24'd0, bus.byte_in} > 32'(DEPTH);

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = GET_CNT;
            GET_CNT: if (fire) begin
                if (bus.byte_in == 8'd0) state_d = END_ST;
                else if (too_big)        state_d = ERR;
                else                     state_d = GET_HI;
            end
            GET_HI:  if (fire) state_d = GET_LO;
            GET_LO:  if (fire) state_d = WRITE;
            WRITE:   state_d = last_word ? END_ST : GET_HI;
`ifdef LOADER_CHECKSUM_EN
            GET_SUM: if (fire) state_d = (bus.byte_in == sum) ? RELEASE : ERR;
`endif
            RELEASE: state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode (pure function of the registered state)
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.word_we    = 1'b0;
        done           = 1'b0;
        busy           = 1'b0;
        case (state_q)
            GET_CNT, GET_HI, GET_LO: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            GET_SUM: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
            end
`endif
            WRITE: begin
                bus.word_we = 1'b1;
                busy        = 1'b1;
            end
            RELEASE: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath and sticky flags
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            index         <= '0;
            count         <= '0;
            hi            <= 8'd0;
            bus.data_word <= 16'd0;
            bus.word_addr <= '0;
            cpu_clear     <= 1'b1;
            error         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum           <= 8'd0;
`endif
        end else begin
            if (state_q == IDLE && start) begin
                index     <= '0;
                cpu_clear <= 1'b1;
                error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                sum       <= 8'd0;
`endif
            end
            // cpu_clear drops on the edge that leaves RELEASE.
            if (state_q == RELEASE) cpu_clear <= 1'b0;
            if (state_d == ERR)     error     <= 1'b1;
            if (fire && state_q == GET_CNT) count <= IW'(bus.byte_in);
            if (fire && state_q == GET_HI)  hi    <= bus.byte_in;
            // Word and address are captured as WRITE is entered and then
            // held until the next word completes.
            if (fire && state_q == GET_LO) begin
                bus.data_word <= {hi, bus.byte_in};
                bus.word_addr <= index[ADDR_W-1:0];
            end
            if (state_q == WRITE) index <= index + IW'(1);
`ifdef LOADER_CHECKSUM_EN
            if (fire && (state_q == GET_CNT || state_q == GET_HI || state_q == GET_LO))
                sum <= sum + bus.byte_in;
`endif
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic clear;
    logic start;
    logic cpu_clear, busy, done, error;

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .bus       (bus),
        .cpu_clear (cpu_clear),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed write transactions and flags
    logic [ADDR_W-1:0] wr_addr[$];
    logic [15:0]       wr_data[$];
    int unsigned       wr_cyc[$];
    int                done_cnt;
    bit                err_seen;
    int                clr_bad;

    always @(negedge clk) begin
        if (!clear) begin
            if (bus.word_we) begin
                wr_addr.push_back(bus.word_addr);
                wr_data.push_back(bus.data_word);
                wr_cyc.push_back(cyc);
                if (cpu_clear !== 1'b1) clr_bad++;
            end
            if (done)  done_cnt++;
            if (error) err_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
        err_seen = 1'b0;
        clr_bad  = 0;
    endtask

    // Called at a negedge; returns at a negedge, with acc = cycle tag of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int unsigned acc);
        int w;
        w = 0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        repeat (gap) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 32'(bus.byte_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gap_mode: 0 full rate, 1 valid 1-0-0-1 pattern, 2 random gaps
    task automatic run_load(input logic [7:0] n, input logic [7:0] pay[$], input int gap_mode,
                            input bit bad_sum, input string tag);
        logic [7:0]  stream[$];
        int unsigned lo_cyc[$];
        logic [7:0]  s;
        bit          ok;
        int          exp_writes;
        int          gap;
        int unsigned acc;
        int          w;
        int          lim;

        // Reference: the image is accepted iff N fits (and the sum matches).
        ok         = (n <= DEPTH);
        exp_writes = ok ? int'(n) : 0;
        stream.push_back(n);
        s = n;
        if (ok) begin
            foreach (pay[i]) begin
                stream.push_back(pay[i]);
                s = s + pay[i];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (ok) begin
            stream.push_back(bad_sum ? s + 8'd1 : s);
            if (bad_sum) ok = 1'b0;
        end
`else
        if (bad_sum) ok = 1'b0;
`endif

        clear_monitor();
        pulse_start();
        check({tag, "_busy_on_start"}, 32'(busy), 32'd1);
        check({tag, "_err_clr_on_start"}, 32'(error), 32'd0);
        check({tag, "_cpu_clear_on_start"}, 32'(cpu_clear), 32'd1);

        foreach (stream[i]) begin
            gap = (gap_mode == 1) ? ((i % 2 == 1) ? 2 : 0)
                : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            send_byte(stream[i], gap, acc);
            if (i >= 2 && i % 2 == 0 && i <= 2 * int'(n) && n <= DEPTH) lo_cyc.push_back(acc);
        end

        w = 0;
        while (done_cnt == 0 && !err_seen && w < 30) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_finished"}, 32'(done_cnt > 0 || err_seen), 32'd1);
        repeat (2) @(negedge clk);

        check({tag, "_nwrites"}, 32'(wr_data.size()), 32'(exp_writes));
        lim = (wr_data.size() < exp_writes) ? wr_data.size() : exp_writes;
        for (int k = 0; k < lim; k++) begin
            check($sformatf("%s_w%0d_data", tag, k), 32'(wr_data[k]), 32'({pay[2*k], pay[2*k+1]}));
            check($sformatf("%s_w%0d_addr", tag, k), 32'(wr_addr[k]), 32'(k % (1 << ADDR_W)));
            if (k < lo_cyc.size())
                check($sformatf("%s_w%0d_lat", tag, k), wr_cyc[k], lo_cyc[k]);
        end
        check({tag, "_done_pulses"}, 32'(done_cnt), ok ? 32'd1 : 32'd0);
        check({tag, "_error"}, 32'(error), ok ? 32'd0 : 32'd1);
        check({tag, "_cpu_clear"}, 32'(cpu_clear), ok ? 32'd0 : 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_ready_end"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_clear_held"}, 32'(clr_bad), 32'd0);
    endtask

    initial begin
        logic [7:0]  pay[$];
        logic [7:0]  empty[$];
        int          nn;
        int unsigned acc;
        int          w;

        clear          = 1'b1;
        start          = 1'b0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        clear_monitor();
        #2;
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_word_we", 32'(bus.word_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_data_word", 32'(bus.data_word), 32'd0);
        check("rst_word_addr", 32'(bus.word_addr), 32'd0);
        check("rst_cpu_clear", 32'(cpu_clear), 32'd1);
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);

        pay = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        run_load(8'd2, pay, 0, 1'b0, "basic");
        run_load(8'd0, empty, 0, 1'b0, "zero");
        run_load(8'(DEPTH + 1), empty, 0, 1'b0, "ovf");
        run_load(8'd2, pay, 1, 1'b0, "bp");
`ifdef LOADER_CHECKSUM_EN
        run_load(8'd2, pay, 0, 1'b1, "badsum");
`endif

        // Reset in the middle of a load, during the first WRITE.
        clear_monitor();
        pulse_start();
        send_byte(8'd2, 0, acc);
        send_byte(8'h12, 0, acc);
        send_byte(8'h34, 0, acc);
        #1;
        check("mid_word_we", 32'(bus.word_we), 32'd1);
        #1;
        clear = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_cpu_clear", 32'(cpu_clear), 32'd1);
        check("mid_word_we_rst", 32'(bus.word_we), 32'd0);
        check("mid_byte_ready", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        w = wr_data.size();
        repeat (4) @(negedge clk);
        check("mid_no_more_writes", 32'(wr_data.size()), 32'(w));
        run_load(8'd2, pay, 0, 1'b0, "after_rst");

        // Boundary counts, then randomised images with random stalls.
        pay.delete();
        for (int j = 0; j < 2 * DEPTH; j++) pay.push_back(8'($urandom));
        run_load(8'(DEPTH), pay, 2, 1'b0, "full");
        pay = '{8'h5A, 8'hA5};
        run_load(8'd1, pay, 0, 1'b0, "one");
        for (int r = 0; r < 6; r++) begin
            nn = int'($urandom_range(0, DEPTH + 2));
            pay.delete();
            if (nn <= DEPTH)
                for (int j = 0; j < 2 * nn; j++) pay.push_back(8'($urandom));
            run_load(8'(nn), pay, 2, 1'b0, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
